// File: rtl/pc_sequencer.sv
// Program-counter unit with stall, PC-relative branch adder and optional return-address stack.
// Define PC_SEQ_RAS_EN to build the RAS; without it ret always jumps to qs and call is ignored.
module pc_sequencer #(
    parameter int             PB        = 32,
    parameter int             N         = 32,
    parameter int             IMM_BITS  = 26,
    parameter int             RAS_DEPTH = 4,
    parameter logic [PB-1:0]  RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [1:0]          sel,
    input  logic                br_taken,
    input  logic [IMM_BITS-1:0] imm,
    input  logic [N-1:0]        qs,
    input  logic                call,
    input  logic                ret,
    output logic [PB-1:0]       pc,
    output logic [PB-1:0]       pc_plus1,
    output logic                redirect,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_ovf
);

    localparam logic [PB-1:0] PC_ONE = PB'(1);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_JIMM   = 2'b01,
        SEL_JREG   = 2'b10,
        SEL_BRANCH = 2'b11
    } sel_e;

    function automatic logic [PB-1:0] sext_imm(input logic [IMM_BITS-1:0] v);
        logic signed [IMM_BITS-1:0] s;
        s = v;
        return PB'(s);
    endfunction

    function automatic logic [PB-1:0] branch_target(input logic [PB-1:0] base,
                                                    input logic [IMM_BITS-1:0] off);
        logic signed [PB-1:0] sum;
        sum = $signed(base) + $signed(sext_imm(off));
        return sum;
    endfunction

    logic [PB-1:0] pc_q, pc_d;
    logic          redirect_q, redirect_d;
    logic [PB-1:0] sel_tgt;
    logic          sel_redir;

    assign pc       = pc_q;
    assign pc_plus1 = pc_q + PC_ONE;
    assign redirect = redirect_q;

    always_comb begin
        sel_tgt   = pc_plus1;
        sel_redir = 1'b0;
        case (sel_e'(sel))
            SEL_SEQ: begin
                sel_tgt   = pc_plus1;
                sel_redir = 1'b0;
            end
            SEL_JIMM: begin
                sel_tgt   = PB'(imm);
                sel_redir = 1'b1;
            end
            SEL_JREG: begin
                sel_tgt   = qs[PB-1:0];
                sel_redir = 1'b1;
            end
            SEL_BRANCH: begin
                sel_tgt   = br_taken ? branch_target(pc_plus1, imm) : pc_plus1;
                sel_redir = br_taken;
            end
            default: ;
        endcase
    end

`ifdef PC_SEQ_RAS_EN
    localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [PB-1:0] ras_q [RAS_DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          ras_we;
    logic [AW-1:0] ras_wa;
    logic [AW-1:0] top_idx;
    logic          unused_qs;

    assign unused_qs = ^qs;
    assign top_idx   = wp_q - AW'(1);

    // Pointer wp_q names the next free slot; the top entry sits just below it.
    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        ras_we     = 1'b0;
        ras_wa     = wp_q;
        if (!stall) begin
            if (ret) begin
                redirect_d = 1'b1;
                if (cnt_q != '0) begin
                    pc_d = ras_q[top_idx];
                    if (call) begin
                        ras_we = 1'b1;
                        ras_wa = top_idx;
                    end else begin
                        wp_d  = top_idx;
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    pc_d = qs[PB-1:0];
                    if (call) begin
                        ras_we = 1'b1;
                        ras_wa = wp_q;
                        wp_d   = wp_q + AW'(1);
                        cnt_d  = CW'(1);
                    end
                end
            end else begin
                pc_d       = sel_tgt;
                redirect_d = sel_redir;
                if (call) begin
                    // A full stack overwrites its oldest entry, which is the slot at wp_q.
                    ras_we = 1'b1;
                    ras_wa = wp_q;
                    wp_d   = wp_q + AW'(1);
                    if (cnt_q == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_wa] <= pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_FULL);
    assign ras_ovf   = ovf_q;
`else
    logic unused_in;

    assign unused_in = ^{qs, call};

    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        if (!stall) begin
            if (ret) begin
                pc_d       = qs[PB-1:0];
                redirect_d = 1'b1;
            end else begin
                pc_d       = sel_tgt;
                redirect_d = sel_redir;
            end
        end
    end

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for next-PC selection, hand sequences for RAS, stall and reset.
module tb_pc_sequencer;

    localparam int PB       = 32;
    localparam int N        = 32;
    localparam int IMM_BITS = 26;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                stall = 1'b0;
    logic [1:0]          sel = 2'b00;
    logic                br_taken = 1'b0;
    logic [IMM_BITS-1:0] imm = '0;
    logic [N-1:0]        qs = '0;
    logic                call = 1'b0;
    logic                ret = 1'b0;
    logic [PB-1:0]       pc;
    logic [PB-1:0]       pc_plus1;
    logic                redirect;
    logic                ras_empty;
    logic                ras_full;
    logic                ras_ovf;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .PB(PB), .N(N), .IMM_BITS(IMM_BITS), .RAS_DEPTH(4), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .sel(sel), .br_taken(br_taken),
        .imm(imm), .qs(qs), .call(call), .ret(ret), .pc(pc), .pc_plus1(pc_plus1),
        .redirect(redirect), .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  sel;
        logic        br;
        logic [25:0] imm;
        logic [31:0] qs;
        logic        ret;
        logic [31:0] epc;
        logic        erd;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] epc, input logic erd,
                             input logic ee, input logic ef, input logic eo);
        chk({tag, " pc"}, pc, epc);
        chk({tag, " pc_plus1"}, pc_plus1, epc + 32'd1);
        chk({tag, " redirect"}, {31'd0, redirect}, {31'd0, erd});
        chk({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, ee});
        chk({tag, " ras_full"}, {31'd0, ras_full}, {31'd0, ef});
        chk({tag, " ras_ovf"}, {31'd0, ras_ovf}, {31'd0, eo});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic s, input logic [1:0] sl, input logic c,
                      input logic r, input logic [25:0] im, input logic [31:0] q,
                      input logic [31:0] epc, input logic erd, input logic ee,
                      input logic ef, input logic eo);
        stall    = s;
        sel      = sl;
        br_taken = 1'b0;
        call     = c;
        ret      = r;
        imm      = im;
        qs       = q;
        cyc();
        chk_state(tag, epc, erd, ee, ef, eo);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'b00, 1'b0, 26'h0,       32'h0,         1'b0, 32'h1,         1'b0};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 26'h0,       32'h0,         1'b0, 32'h2,         1'b0};
        tbl[2]  = '{1'b0, 2'b00, 1'b0, 26'h0,       32'h0,         1'b0, 32'h3,         1'b0};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 26'd10,      32'h0,         1'b0, 32'd10,        1'b1};
        tbl[4]  = '{1'b0, 2'b11, 1'b1, 26'h3FFFFFC, 32'h0,         1'b0, 32'd7,         1'b1};
        tbl[5]  = '{1'b0, 2'b01, 1'b0, 26'd10,      32'h0,         1'b0, 32'd10,        1'b1};
        tbl[6]  = '{1'b0, 2'b11, 1'b0, 26'h3FFFFFC, 32'h0,         1'b0, 32'd11,        1'b0};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 26'd50,      32'h0,         1'b0, 32'd11,        1'b0};
        tbl[8]  = '{1'b0, 2'b10, 1'b0, 26'h0,       32'hFFFFFFFF,  1'b0, 32'hFFFFFFFF,  1'b1};
        tbl[9]  = '{1'b0, 2'b00, 1'b0, 26'h0,       32'h0,         1'b0, 32'h0,         1'b0};
        tbl[10] = '{1'b0, 2'b11, 1'b1, 26'h3FFFFFE, 32'h0,         1'b0, 32'hFFFFFFFF,  1'b1};
        tbl[11] = '{1'b0, 2'b11, 1'b1, 26'd5,       32'h0,         1'b0, 32'h5,         1'b1};
        tbl[12] = '{1'b0, 2'b11, 1'b1, 26'h1FFFFFF, 32'h0,         1'b0, 32'h02000005,  1'b1};
        tbl[13] = '{1'b0, 2'b01, 1'b0, 26'h3FFFFFF, 32'h0,         1'b0, 32'h03FFFFFF,  1'b1};
        tbl[14] = '{1'b1, 2'b10, 1'b0, 26'h0,       32'h123,       1'b1, 32'h03FFFFFF,  1'b0};

        #2;
        chk_state("reset", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            stall    = tbl[i].stall;
            sel      = tbl[i].sel;
            br_taken = tbl[i].br;
            imm      = tbl[i].imm;
            qs       = tbl[i].qs;
            call     = 1'b0;
            ret      = tbl[i].ret;
            cyc();
            chk_state($sformatf("vec%0d", i), tbl[i].epc, tbl[i].erd, 1'b1, 1'b0, 1'b0);
        end

`ifdef PC_SEQ_RAS_EN
        st("to5",      0, 2'b01, 0, 0, 26'd5,    32'h0,  32'd5,    1, 1, 0, 0);
        st("call100",  0, 2'b01, 1, 0, 26'd100,  32'h0,  32'd100,  1, 0, 0, 0);
        st("call200",  0, 2'b01, 1, 0, 26'd200,  32'h0,  32'd200,  1, 0, 0, 0);
        st("ret101",   0, 2'b00, 0, 1, 26'd0,    32'h0,  32'd101,  1, 0, 0, 0);
        st("ret6",     0, 2'b00, 0, 1, 26'd0,    32'h0,  32'd6,    1, 1, 0, 0);
        st("push1",    0, 2'b01, 1, 0, 26'h10,   32'h0,  32'h10,   1, 0, 0, 0);
        st("push2",    0, 2'b01, 1, 0, 26'h20,   32'h0,  32'h20,   1, 0, 0, 0);
        st("push3",    0, 2'b01, 1, 0, 26'h30,   32'h0,  32'h30,   1, 0, 0, 0);
        st("push4",    0, 2'b01, 1, 0, 26'h40,   32'h0,  32'h40,   1, 0, 1, 0);
        st("push5",    0, 2'b01, 1, 0, 26'h50,   32'h0,  32'h50,   1, 0, 1, 1);
        st("pop1",     0, 2'b00, 0, 1, 26'h0,    32'h0,  32'h41,   1, 0, 0, 1);
        st("pop2",     0, 2'b00, 0, 1, 26'h0,    32'h0,  32'h31,   1, 0, 0, 1);
        st("pop3",     0, 2'b00, 0, 1, 26'h0,    32'h0,  32'h21,   1, 0, 0, 1);
        st("pop4",     0, 2'b00, 0, 1, 26'h0,    32'h0,  32'h11,   1, 1, 0, 1);
        st("pop_empty",0, 2'b00, 0, 1, 26'h0,    32'h40, 32'h40,   1, 1, 0, 1);
        st("cr_empty", 0, 2'b00, 1, 1, 26'h0,    32'h80, 32'h80,   1, 0, 0, 1);
        st("cr_full",  0, 2'b00, 1, 1, 26'h0,    32'h0,  32'h41,   1, 0, 0, 1);
        st("cr_after", 0, 2'b00, 0, 1, 26'h0,    32'h0,  32'h81,   1, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            st($sformatf("stall%0d", k), 1, 2'b01, 1, 0, 26'h200, 32'h0, 32'h81, 0, 1, 0, 1);
        end
        st("unstall",  0, 2'b01, 1, 0, 26'h200,  32'h0,  32'h200,  1, 0, 0, 1);
        st("ret_once", 0, 2'b00, 0, 1, 26'h0,    32'h0,  32'h82,   1, 1, 0, 1);
        st("ret_fb",   0, 2'b00, 0, 1, 26'h0,    32'h33, 32'h33,   1, 1, 0, 1);
        st("pre_a",    0, 2'b01, 1, 0, 26'h300,  32'h0,  32'h300,  1, 0, 0, 1);
        st("pre_b",    0, 2'b01, 1, 0, 26'h55,   32'h0,  32'h55,   1, 0, 0, 1);
`else
        st("ret_qs",   0, 2'b00, 0, 1, 26'h0,    32'h40, 32'h40,   1, 1, 0, 0);
        st("call_nop", 0, 2'b01, 1, 0, 26'h100,  32'h0,  32'h100,  1, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            st($sformatf("callx%0d", k), 0, 2'b01, 1, 0, 26'h100 + 26'(k), 32'h0,
               32'h100 + 32'(k), 1, 1, 0, 0);
        end
        st("cr_qs",    0, 2'b00, 1, 1, 26'h0,    32'h77, 32'h77,   1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            st($sformatf("stall%0d", k), 1, 2'b01, 1, 0, 26'h200, 32'h0, 32'h77, 0, 1, 0, 0);
        end
        st("unstall",  0, 2'b01, 1, 0, 26'h200,  32'h0,  32'h200,  1, 1, 0, 0);
        st("pre_b",    0, 2'b01, 0, 0, 26'h55,   32'h0,  32'h55,   1, 1, 0, 0);
`endif

        // Reset asserted between edges must act immediately.
        stall = 1'b0;
        sel   = 2'b00;
        call  = 1'b0;
        ret   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        st("post_rst", 0, 2'b00, 0, 0, 26'h0, 32'h0, 32'h1, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
